// File: rtl/caliptra_fpga_apb_seq_pkg.sv
// Shared types for the two-requester APB sequencer: FSM state encoding and
// bit positions inside rsp_err.
package caliptra_fpga_apb_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2,
    ST_RESP   = 2'd3
  } seq_state_e;

  localparam int unsigned ERR_SLV_BIT = 0;
  localparam int unsigned ERR_TMO_BIT = 1;

endpackage

// File: rtl/caliptra_fpga_rr_arb2.sv
// Two-way round-robin arbiter: combinational one-hot grant, last-grant pointer
// advanced only when the grant is accepted.
module caliptra_fpga_rr_arb2
  import caliptra_fpga_apb_seq_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       accept,
  output logic [1:0] gnt
);

  logic last_q, last_d;

  always_comb begin
    unique case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = last_q ? 2'b01 : 2'b10;
      default: gnt = 2'b00;
    endcase
    last_d = (accept && (gnt != 2'b00)) ? gnt[1] : last_q;
  end

  // Pointer starts at 1 so requester 0 wins the first tie.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) last_q <= 1'b1;
    else        last_q <= last_d;
  end

endmodule

// File: rtl/caliptra_fpga_apb_sequencer.sv
// Arbitrates two request/response ports onto one APB manager interface.
// Define CALIPTRA_FPGA_APB_SEQ_TIMEOUT_EN to bound the ACCESS phase to TIMEOUT_CYC cycles.
module caliptra_fpga_apb_sequencer
  import caliptra_fpga_apb_seq_pkg::*;
#(
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned USER_W      = 32,
  parameter int unsigned TIMEOUT_CYC = 1024
) (
  input  logic                  aclk,
  input  logic                  rstn,
  input  logic [1:0]            req_valid,
  output logic [1:0]            req_ready,
  input  logic [1:0]            req_write,
  input  logic [2*ADDR_W-1:0]   req_addr,
  input  logic [2*DATA_W-1:0]   req_wdata,
  input  logic [2*USER_W-1:0]   req_pauser,
  input  logic [5:0]            req_pprot,
  output logic [1:0]            rsp_valid,
  input  logic [1:0]            rsp_ready,
  output logic [DATA_W-1:0]     rsp_rdata,
  output logic [1:0]            rsp_err,
  output logic                  PSEL,
  output logic                  PENABLE,
  output logic                  PWRITE,
  output logic [ADDR_W-1:0]     PADDR,
  output logic [DATA_W-1:0]     PWDATA,
  output logic [USER_W-1:0]     PAUSER,
  output logic [2:0]            PPROT,
  input  logic [DATA_W-1:0]     PRDATA,
  input  logic                  PREADY,
  input  logic                  PSLVERR,
  output logic                  busy
);

  if (TIMEOUT_CYC < 1 || TIMEOUT_CYC > 65535) begin : g_bad_timeout
    $error("TIMEOUT_CYC must be within 1..65535");
  end

  seq_state_e          state_q, state_d;
  logic                gsel_q, gsel_d;
  logic                psel_q, psel_d;
  logic                penable_q, penable_d;
  logic                pwrite_q, pwrite_d;
  logic [ADDR_W-1:0]   paddr_q, paddr_d;
  logic [DATA_W-1:0]   pwdata_q, pwdata_d;
  logic [USER_W-1:0]   pauser_q, pauser_d;
  logic [2:0]          pprot_q, pprot_d;
  logic [1:0]          rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic                slverr_q, slverr_d;
  logic                busy_q, busy_d;
  logic [1:0]          gnt;
`ifdef CALIPTRA_FPGA_APB_SEQ_TIMEOUT_EN
  logic                tmo_q, tmo_d;
  logic [15:0]         cnt_q, cnt_d;
`endif

  caliptra_fpga_rr_arb2 u_arb (
    .clk    (aclk),
    .rst_n  (rstn),
    .req    (req_valid),
    .accept (state_q == ST_IDLE),
    .gnt    (gnt)
  );

  // Gated by rstn so the handshake is silent while reset is asserted.
  assign req_ready = (state_q == ST_IDLE && rstn) ? gnt : 2'b00;

  always_comb begin
    state_d     = state_q;
    gsel_d      = gsel_q;
    psel_d      = psel_q;
    penable_d   = penable_q;
    pwrite_d    = pwrite_q;
    paddr_d     = paddr_q;
    pwdata_d    = pwdata_q;
    pauser_d    = pauser_q;
    pprot_d     = pprot_q;
    rsp_valid_d = rsp_valid_q;
    rdata_d     = rdata_q;
    slverr_d    = slverr_q;
`ifdef CALIPTRA_FPGA_APB_SEQ_TIMEOUT_EN
    tmo_d       = tmo_q;
    cnt_d       = cnt_q;
`endif
    unique case (state_q)
      ST_IDLE: begin
        if (gnt != 2'b00) begin
          state_d   = ST_SETUP;
          gsel_d    = gnt[1];
          psel_d    = 1'b1;
          penable_d = 1'b0;
          pwrite_d  = gnt[1] ? req_write[1] : req_write[0];
          paddr_d   = gnt[1] ? req_addr[ADDR_W +: ADDR_W]   : req_addr[0 +: ADDR_W];
          pwdata_d  = gnt[1] ? req_wdata[DATA_W +: DATA_W]  : req_wdata[0 +: DATA_W];
          pauser_d  = gnt[1] ? req_pauser[USER_W +: USER_W] : req_pauser[0 +: USER_W];
          pprot_d   = gnt[1] ? req_pprot[5:3] : req_pprot[2:0];
        end
      end
      ST_SETUP: begin
        state_d   = ST_ACCESS;
        penable_d = 1'b1;
`ifdef CALIPTRA_FPGA_APB_SEQ_TIMEOUT_EN
        cnt_d     = '0;
`endif
      end
      ST_ACCESS: begin
        if (PREADY) begin
          state_d     = ST_RESP;
          psel_d      = 1'b0;
          penable_d   = 1'b0;
          rsp_valid_d = gsel_q ? 2'b10 : 2'b01;
          rdata_d     = pwrite_q ? '0 : PRDATA;
          slverr_d    = PSLVERR;
`ifdef CALIPTRA_FPGA_APB_SEQ_TIMEOUT_EN
          tmo_d       = 1'b0;
        end else if (cnt_q == 16'(TIMEOUT_CYC - 1)) begin
          state_d     = ST_RESP;
          psel_d      = 1'b0;
          penable_d   = 1'b0;
          rsp_valid_d = gsel_q ? 2'b10 : 2'b01;
          rdata_d     = '0;
          slverr_d    = 1'b0;
          tmo_d       = 1'b1;
        end else begin
          cnt_d       = cnt_q + 16'd1;
`endif
        end
      end
      ST_RESP: begin
        if (rsp_ready[gsel_q]) begin
          state_d     = ST_IDLE;
          rsp_valid_d = 2'b00;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge aclk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= ST_IDLE;
      gsel_q      <= 1'b0;
      psel_q      <= 1'b0;
      penable_q   <= 1'b0;
      pwrite_q    <= 1'b0;
      paddr_q     <= '0;
      pwdata_q    <= '0;
      pauser_q    <= '0;
      pprot_q     <= '0;
      rsp_valid_q <= 2'b00;
      rdata_q     <= '0;
      slverr_q    <= 1'b0;
      busy_q      <= 1'b0;
`ifdef CALIPTRA_FPGA_APB_SEQ_TIMEOUT_EN
      tmo_q       <= 1'b0;
      cnt_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      gsel_q      <= gsel_d;
      psel_q      <= psel_d;
      penable_q   <= penable_d;
      pwrite_q    <= pwrite_d;
      paddr_q     <= paddr_d;
      pwdata_q    <= pwdata_d;
      pauser_q    <= pauser_d;
      pprot_q     <= pprot_d;
      rsp_valid_q <= rsp_valid_d;
      rdata_q     <= rdata_d;
      slverr_q    <= slverr_d;
      busy_q      <= busy_d;
`ifdef CALIPTRA_FPGA_APB_SEQ_TIMEOUT_EN
      tmo_q       <= tmo_d;
      cnt_q       <= cnt_d;
`endif
    end
  end

  always_comb begin
    rsp_err              = 2'b00;
    rsp_err[ERR_SLV_BIT] = slverr_q;
`ifdef CALIPTRA_FPGA_APB_SEQ_TIMEOUT_EN
    rsp_err[ERR_TMO_BIT] = tmo_q;
`else
    rsp_err[ERR_TMO_BIT] = 1'b0;
`endif
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rdata_q;
  assign PSEL      = psel_q;
  assign PENABLE   = penable_q;
  assign PWRITE    = pwrite_q;
  assign PADDR     = paddr_q;
  assign PWDATA    = pwdata_q;
  assign PAUSER    = pauser_q;
  assign PPROT     = pprot_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_caliptra_fpga_apb_sequencer.sv
// Self-checking bench for caliptra_fpga_apb_sequencer: transaction-level model
// with per-cycle compare; honours CALIPTRA_FPGA_APB_SEQ_TIMEOUT_EN.
module tb_caliptra_fpga_apb_sequencer;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int UW = 32;
  localparam int TMO = 8;

  logic aclk = 1'b0;
  logic rstn = 1'b0;
  logic [1:0] req_valid = '0, req_ready, req_write = '0;
  logic [2*AW-1:0] req_addr = '0;
  logic [2*DW-1:0] req_wdata = '0;
  logic [2*UW-1:0] req_pauser = '0;
  logic [5:0] req_pprot = '0;
  logic [1:0] rsp_valid, rsp_ready = '0, rsp_err;
  logic [DW-1:0] rsp_rdata;
  logic PSEL, PENABLE, PWRITE, busy;
  logic [AW-1:0] PADDR;
  logic [DW-1:0] PWDATA;
  logic [UW-1:0] PAUSER;
  logic [2:0] PPROT;
  logic [DW-1:0] PRDATA = '0;
  logic PREADY = 1'b0, PSLVERR = 1'b0;

  caliptra_fpga_apb_sequencer #(.ADDR_W(AW), .DATA_W(DW), .USER_W(UW), .TIMEOUT_CYC(TMO)) dut (
    .aclk(aclk), .rstn(rstn), .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_pauser(req_pauser), .req_pprot(req_pprot),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA),
    .PAUSER(PAUSER), .PPROT(PPROT), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR), .busy(busy)
  );

  always #5 aclk = ~aclk;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  always @(posedge aclk) cyc <= cyc + 1;

  // Per-requester request contents.
  logic          m_write [2];
  logic [AW-1:0] m_addr  [2];
  logic [DW-1:0] m_wdata [2];
  logic [UW-1:0] m_user  [2];
  logic [2:0]    m_prot  [2];
  int            last_m = 1;

  // Expected outputs for the current cycle.
  bit            chk_en = 0;
  logic [1:0]    exp_req_ready = '0, exp_rsp_valid = '0, exp_err = '0;
  logic          exp_psel = 0, exp_penable = 0, exp_busy = 0, exp_pwrite = 0;
  logic [AW-1:0] exp_paddr = '0;
  logic [DW-1:0] exp_pwdata = '0, exp_rdata = '0;
  logic [UW-1:0] exp_pauser = '0;
  logic [2:0]    exp_pprot = '0;

  // Observations used by literal checks.
  int            gq[$];
  logic [UW-1:0] uq[$];
  int            ready_cyc = 0, rsp_cyc = 0, acc_len = 0;
  bit            rsp_seen = 0;
  logic [AW-1:0] last_paddr = '0;
  logic [DW-1:0] last_rdata = '0;
  logic [1:0]    last_err = '0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, act, req, cyc);
    end
  endtask

  function automatic int rr_pick(input logic [1:0] v, input int last);
    if (v == 2'b11) return (last == 0) ? 1 : 0;
    return v[1] ? 1 : 0;
  endfunction

  always @(negedge aclk) begin
    if (chk_en) begin
      chk("req_ready", req_ready, exp_req_ready);
      chk("psel", PSEL, exp_psel);
      chk("penable", PENABLE, exp_penable);
      chk("busy", busy, exp_busy);
      chk("rsp_valid", rsp_valid, exp_rsp_valid);
      if (exp_psel) begin
        chk("pwrite", PWRITE, exp_pwrite);
        chk("paddr", PADDR, exp_paddr);
        chk("pwdata", PWDATA, exp_pwdata);
        chk("pauser", PAUSER, exp_pauser);
        chk("pprot", PPROT, exp_pprot);
      end
      if (exp_rsp_valid != 2'b00) begin
        chk("rsp_rdata", rsp_rdata, exp_rdata);
        chk("rsp_err", rsp_err, exp_err);
      end
      if (req_ready != 2'b00) begin
        gq.push_back(req_ready[1] ? 1 : 0);
        ready_cyc = cyc;
      end
      if (PSEL && !PENABLE) begin
        uq.push_back(PAUSER);
        last_paddr = PADDR;
        acc_len = 0;
      end
      if (PENABLE) acc_len++;
      if (rsp_valid != 2'b00 && !rsp_seen) begin
        rsp_seen = 1;
        rsp_cyc = cyc;
        last_rdata = rsp_rdata;
        last_err = rsp_err;
      end
      if (rsp_valid == 2'b00) rsp_seen = 0;
    end
  end

  task automatic step();
    @(posedge aclk);
    #1;
  endtask

  task automatic exp_idle();
    exp_req_ready = '0; exp_psel = 0; exp_penable = 0; exp_busy = 0; exp_rsp_valid = '0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      step();
      req_valid = '0; rsp_ready = '0;
      exp_idle();
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_req_ready"}, req_ready, 0);
    chk({tag, "_rsp_valid"}, rsp_valid, 0);
    chk({tag, "_rsp_rdata"}, rsp_rdata, 0);
    chk({tag, "_rsp_err"}, rsp_err, 0);
    chk({tag, "_psel"}, PSEL, 0);
    chk({tag, "_penable"}, PENABLE, 0);
    chk({tag, "_pwrite"}, PWRITE, 0);
    chk({tag, "_paddr"}, PADDR, 0);
    chk({tag, "_pwdata"}, PWDATA, 0);
    chk({tag, "_pauser"}, PAUSER, 0);
    chk({tag, "_pprot"}, PPROT, 0);
    chk({tag, "_busy"}, busy, 0);
  endtask

  task automatic do_reset();
    chk_en = 0;
    step();
    rstn = 0; req_valid = '0; rsp_ready = '0; PREADY = 0;
    step();
    step();
    rstn = 1; last_m = 1; exp_idle(); chk_en = 1;
  endtask

  // One transaction: waits<0 means PREADY never comes (timeout build only).
  task automatic do_txn(input logic [1:0] valid, input int waits, input logic [DW-1:0] prd,
                        input logic slverr, input int hold, input bit glitch);
    int g;
    logic [1:0] oh, drv;
    step();
    req_valid = valid; rsp_ready = '0;
    g = rr_pick(valid, last_m);
    oh = (g == 1) ? 2'b10 : 2'b01;
    last_m = g;
    exp_idle();
    exp_req_ready = oh;
    exp_pwrite = m_write[g]; exp_paddr = m_addr[g]; exp_pwdata = m_wdata[g];
    exp_pauser = m_user[g]; exp_pprot = m_prot[g];
    drv = glitch ? (valid | ~oh) : valid;
    step();
    req_valid = drv;
    exp_req_ready = '0; exp_psel = 1; exp_penable = 0; exp_busy = 1;
    if (waits < 0) begin
      for (int w = 0; w < TMO; w++) begin
        step(); PREADY = 0; PRDATA = prd; exp_penable = 1;
      end
      exp_rdata = '0; exp_err = 2'b10;
    end else begin
      for (int w = 0; w <= waits; w++) begin
        step(); PREADY = (w == waits); PRDATA = prd; PSLVERR = slverr; exp_penable = 1;
      end
      exp_rdata = m_write[g] ? '0 : prd; exp_err = {1'b0, slverr};
    end
    step();
    PREADY = 0; PSLVERR = 0; PRDATA = '0;
    exp_psel = 0; exp_penable = 0; exp_rsp_valid = oh;
    rsp_ready = (hold == 0) ? oh : 2'b00;
    for (int h = 1; h <= hold; h++) begin
      step();
      rsp_ready = (h == hold) ? oh : 2'b00;
    end
  endtask

  task automatic reset_in_access(input int n);
    step();
    req_valid = 2'b11; rsp_ready = '0;
    exp_idle(); exp_req_ready = (rr_pick(2'b11, last_m) == 1) ? 2'b10 : 2'b01;
    last_m = rr_pick(2'b11, last_m);
    exp_pwrite = m_write[last_m]; exp_paddr = m_addr[last_m]; exp_pwdata = m_wdata[last_m];
    exp_pauser = m_user[last_m]; exp_pprot = m_prot[last_m];
    step();
    exp_req_ready = '0; exp_psel = 1; exp_busy = 1;
    for (int i = 0; i < n; i++) begin
      step(); PREADY = 0; exp_penable = 1;
    end
    #2;
    chk("stuck_psel", PSEL, 1);
    chk("stuck_penable", PENABLE, 1);
    chk_en = 0;
    rstn = 0;
    #1;
    chk_all_zero("async_rst");
    step();
    req_valid = '0;
    step();
    rstn = 1; last_m = 1; exp_idle(); chk_en = 1;
  endtask

  initial begin
    logic [UW-1:0] exp_users [4];
    int exp_order [4];
    m_write[0] = 1; m_addr[0] = 32'h3000_0010; m_wdata[0] = 32'hDEAD_BEEF; m_user[0] = 32'hAAAA_0000; m_prot[0] = 3'b010;
    m_write[1] = 0; m_addr[1] = 32'h4000_0020; m_wdata[1] = 32'h0BAD_F00D; m_user[1] = 32'h5555_0001; m_prot[1] = 3'b101;
    req_write  = {m_write[1], m_write[0]};
    req_addr   = {m_addr[1], m_addr[0]};
    req_wdata  = {m_wdata[1], m_wdata[0]};
    req_pauser = {m_user[1], m_user[0]};
    req_pprot  = {m_prot[1], m_prot[0]};
    exp_order = '{0, 1, 0, 1};
    exp_users = '{32'hAAAA_0000, 32'h5555_0001, 32'hAAAA_0000, 32'h5555_0001};

    step();
    step();
    chk_all_zero("reset");
    rstn = 1; exp_idle(); chk_en = 1;
    idle(2);

    // Zero-wait write from requester 0.
    do_txn(2'b01, 0, 32'h0, 0, 0, 0);
    idle(1);
    chk("wr_latency", rsp_cyc - ready_cyc, 3);
    chk("wr_paddr_lit", last_paddr, 32'h3000_0010);
    chk("wr_err_lit", last_err, 2'b00);
    chk("wr_access_len", acc_len, 1);

    // Read from requester 1 with two wait states.
    do_txn(2'b10, 2, 32'h1234_5678, 0, 0, 0);
    idle(1);
    chk("rd_access_len", acc_len, 3);
    chk("rd_rdata_lit", last_rdata, 32'h1234_5678);

    // Four back-to-back ties from a fresh reset.
    do_reset();
    gq.delete(); uq.delete();
    for (int i = 0; i < 4; i++) do_txn(2'b11, 0, 32'h0000_1000 + i, 0, 0, 0);
    idle(1);
    chk("rr_count", gq.size(), 4);
    chk("rr_user_count", uq.size(), 4);
    for (int i = 0; i < 4 && i < gq.size() && i < uq.size(); i++) begin
      chk("rr_order", gq[i], exp_order[i]);
      chk("rr_pauser", uq[i], exp_users[i]);
    end

    // Slave error with delayed rsp_ready while requester 1 comes and goes.
    do_txn(2'b01, 0, 32'hFFFF_FFFF, 1, 5, 1);
    idle(1);
    chk("slverr_lit", last_err, 2'b01);
    gq.delete();
    do_txn(2'b01, 1, 32'h0, 0, 0, 0);
    idle(1);
    chk("after_drop_grant", (gq.size() == 1) ? gq[0] : -1, 0);

`ifdef CALIPTRA_FPGA_APB_SEQ_TIMEOUT_EN
    do_txn(2'b10, -1, 32'h5A5A_5A5A, 0, 0, 0);
    idle(1);
    chk("tmo_err_lit", last_err, 2'b10);
    chk("tmo_rdata_lit", last_rdata, 0);
    chk("tmo_access_len", acc_len, TMO);
    reset_in_access(3);
`else
    reset_in_access(100);
`endif

    // After reset release requester 0 wins the first tie again.
    gq.delete();
    do_txn(2'b11, 0, 32'hCAFE_F00D, 0, 1, 0);
    idle(2);
    chk("post_rst_grant", (gq.size() >= 1) ? gq[0] : -1, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
